// File: rtl/uc_pkg.sv
// Shared types and helpers for the unit-clause path (arbiter -> ucq).
//   LIT_W    : literal width; literals are signed, magnitude = variable index
//   NUM_VAR  : assignment-table depth (entry 0 is never used)
//   lit_t    : signed literal
//   var_t    : variable index
//   asg_t    : per-variable table entry {assigned, value}
//   lit_class_e : classification of a granted literal
package uc_pkg;

    localparam int unsigned LIT_W   = 9;
    localparam int unsigned NUM_VAR = 2 ** (LIT_W - 1);

    typedef logic signed [LIT_W-1:0] lit_t;
    typedef logic [LIT_W-2:0]        var_t;

    typedef struct packed {
        logic assigned;
        logic value;
    } asg_t;

    typedef enum logic [1:0] {
        INVALID,
        NEW,
        DUP,
        CONFLICT
    } lit_class_e;

    // Magnitude of a literal. The most-negative encoding has no valid
    // magnitude and is filtered out by lit_invalid before this matters.
    function automatic var_t lit_var(lit_t lit);
        return lit[LIT_W-1] ? var_t'(-lit) : var_t'(lit);
    endfunction

    // Zero and the most-negative encoding do not name a variable.
    function automatic logic lit_invalid(lit_t lit);
        return (lit == '0) || (lit == {1'b1, {(LIT_W - 1){1'b0}}});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, with wrap.
//   en        : allow a grant this cycle
//   req       : request vector
//   ptr       : highest-priority index
//   gnt       : one-hot grant (zero when en=0 or no request)
//   gnt_valid : a grant was issued
//   gnt_idx   : index of the granted requester
// The pointer itself is owned by the instantiating block.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [PTR_W-1:0]   gnt_idx
);

    always_comb begin
        int unsigned idx_full;
        logic [PTR_W-1:0] idx;
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx_full  = 0;
        idx       = '0;
        if (en) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx_full = int'(ptr) + off;
                if (idx_full >= NUM_REQ) begin
                    idx_full = idx_full - NUM_REQ;
                end
                idx = PTR_W'(idx_full);
                if (!gnt_valid && req[idx]) begin
                    gnt[idx]  = 1'b1;
                    gnt_valid = 1'b1;
                    gnt_idx   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/uc_arbiter.sv
// Unit Clause Arbiter: round-robin among engine unit-literal requests,
// filters duplicates against a per-variable assignment table, pushes new
// literals into the ucq and raises a sticky conflict on contradictions.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous clear of table, conflict and counters
//   eng_valid/lit : per-engine request and signed literal (packed, eng0 in LSBs)
//   eng_ready     : one-hot ack
//   q_full        : ucq full
//   q_push/q_data : ucq push strobe and literal
//   conflict      : sticky conflict flag; conflict_lit is the offending literal
//   push_cnt      : literals pushed (saturating)
//   dup_cnt       : duplicates dropped (saturating)
module uc_arbiter
    import uc_pkg::*;
#(
    parameter int unsigned DATA_LEN = 512,
    parameter int unsigned NUM_ENG  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic [NUM_ENG-1:0]                    eng_valid,
    input  logic [NUM_ENG*$clog2(DATA_LEN)-1:0]   eng_lit,
    output logic [NUM_ENG-1:0]                    eng_ready,
    input  logic                                  q_full,
    output logic                                  q_push,
    output logic [$clog2(DATA_LEN)-1:0]           q_data,
    output logic                                  conflict,
    output logic [$clog2(DATA_LEN)-1:0]           conflict_lit,
    output logic [CNT_W-1:0]                      push_cnt,
    output logic [CNT_W-1:0]                      dup_cnt
);

    localparam int unsigned LitW = $clog2(DATA_LEN);
    localparam int unsigned PtrW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    asg_t             table_q [NUM_VAR];
    logic [PtrW-1:0]  rr_ptr_q;
    logic             conflict_q;
    lit_t             conflict_lit_q;
    logic [CNT_W-1:0] push_cnt_q;
    logic [CNT_W-1:0] dup_cnt_q;

    logic             arb_en;
    logic [NUM_ENG-1:0] gnt;
    logic             gnt_valid;
    logic [PtrW-1:0]  gnt_idx;
    lit_t             sel_lit;
    var_t             sel_var;
    asg_t             sel_entry;
    lit_class_e       sel_class;

    // Reset gates the grant so the combinational outputs are quiet under reset.
    assign arb_en = rst & ~q_full & ~conflict_q & ~clear;

    rr_arbiter #(
        .NUM_REQ (NUM_ENG),
        .PTR_W   (PtrW)
    ) u_rr (
        .en        (arb_en),
        .req       (eng_valid),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Mux out the granted literal and classify it against the table.
    always_comb begin
        sel_lit = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (gnt[i]) begin
                sel_lit = lit_t'(eng_lit[i*LitW +: LitW]);
            end
        end
        sel_var   = lit_var(sel_lit);
        sel_entry = table_q[sel_var];
        if (lit_invalid(sel_lit)) begin
            sel_class = INVALID;
        end else if (!sel_entry.assigned) begin
            sel_class = NEW;
        end else if (sel_entry.value == ~sel_lit[LIT_W-1]) begin
            sel_class = DUP;
        end else begin
            sel_class = CONFLICT;
        end
    end

    always_comb begin
        eng_ready = gnt;
        q_push    = gnt_valid && (sel_class == NEW);
        q_data    = q_push ? sel_lit : '0;
    end

    // Assignment table; value is 1 for a positive literal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VAR; v++) begin
                table_q[v] <= '0;
            end
        end else if (clear) begin
            for (int v = 0; v < NUM_VAR; v++) begin
                table_q[v] <= '0;
            end
        end else if (q_push) begin
            table_q[sel_var] <= '{assigned: 1'b1, value: ~sel_lit[LIT_W-1]};
        end
    end

    // rr pointer survives clear; a grant never coincides with clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else if (gnt_valid) begin
            rr_ptr_q <= (gnt_idx == PtrW'(NUM_ENG - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            push_cnt_q     <= '0;
            dup_cnt_q      <= '0;
        end else if (clear) begin
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            push_cnt_q     <= '0;
            dup_cnt_q      <= '0;
        end else if (gnt_valid) begin
            unique case (sel_class)
                NEW: begin
                    if (push_cnt_q != '1) push_cnt_q <= push_cnt_q + 1'b1;
                end
                DUP: begin
                    if (dup_cnt_q != '1) dup_cnt_q <= dup_cnt_q + 1'b1;
                end
                CONFLICT: begin
                    conflict_q     <= 1'b1;
                    conflict_lit_q <= sel_lit;
                end
                default: ;
            endcase
        end
    end

    assign conflict     = conflict_q;
    assign conflict_lit = conflict_lit_q;
    assign push_cnt     = push_cnt_q;
    assign dup_cnt      = dup_cnt_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: push, duplicate, conflict, round-robin,
// backpressure, clear, invalid literals and asynchronous reset.
module tb_uc_arbiter;

    localparam int NE = 4;
    localparam int LW = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic [NE-1:0]   eng_valid;
    logic [NE*LW-1:0] eng_lit;
    logic [NE-1:0]   eng_ready;
    logic            q_full;
    logic            q_push;
    logic [LW-1:0]   q_data;
    logic            conflict;
    logic [LW-1:0]   conflict_lit;
    logic [15:0]     push_cnt;
    logic [15:0]     dup_cnt;

    int checks = 0;
    int errors = 0;

    uc_arbiter #(
        .DATA_LEN (512),
        .NUM_ENG  (4),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .eng_valid    (eng_valid),
        .eng_lit      (eng_lit),
        .eng_ready    (eng_ready),
        .q_full       (q_full),
        .q_push       (q_push),
        .q_data       (q_data),
        .conflict     (conflict),
        .conflict_lit (conflict_lit),
        .push_cnt     (push_cnt),
        .dup_cnt      (dup_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lv(input int v);
        logic [31:0] t;
        t = v;
        return t[LW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_eng(input int i, input int v, input logic val);
        eng_lit[i*LW +: LW] = lv(v);
        eng_valid[i]        = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; q_full = 1'b0;
        eng_valid = '0; eng_lit = '0;
        set_eng(0, 5, 1'b1);
        #1;
        // Reset state; request pending but must not be granted.
        chk("rst_ready", eng_ready, 0);
        chk("rst_push", q_push, 0);
        chk("rst_qdata", q_data, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_clit", conflict_lit, 0);
        chk("rst_pcnt", push_cnt, 0);
        chk("rst_dcnt", dup_cnt, 0);
        #1 rst = 1'b1;
        #1;
        // Basic push of +5 from eng0.
        chk("push_ready", eng_ready, 4'b0001);
        chk("push_push", q_push, 1);
        chk("push_qdata", q_data, lv(5));
        tick();
        chk("push_pcnt", push_cnt, 1);

        // Duplicate +5 from eng1 (ptr=1).
        eng_valid = '0;
        set_eng(1, 5, 1'b1);
        #1;
        chk("dup_ready", eng_ready, 4'b0010);
        chk("dup_push", q_push, 0);
        tick();
        chk("dup_dcnt", dup_cnt, 1);
        chk("dup_pcnt", push_cnt, 1);

        // Conflict -5 from eng2 (ptr=2).
        eng_valid = '0;
        set_eng(2, -5, 1'b1);
        #1;
        chk("cf_ready", eng_ready, 4'b0100);
        chk("cf_push", q_push, 0);
        tick();
        chk("cf_flag", conflict, 1);
        chk("cf_lit", conflict_lit, lv(-5));

        // Sticky: all requests blocked.
        set_eng(0, 30, 1'b1); set_eng(1, 31, 1'b1); set_eng(3, 33, 1'b1);
        #1;
        chk("blk_ready", eng_ready, 0);
        chk("blk_push", q_push, 0);
        tick();
        chk("blk_ready2", eng_ready, 0);
        chk("blk_flag", conflict, 1);

        // Clear with eng0 +5 requesting in the same cycle (ptr=3).
        eng_valid = '0;
        set_eng(0, 5, 1'b1);
        clear = 1'b1;
        #1;
        chk("clr_ready", eng_ready, 0);
        chk("clr_push", q_push, 0);
        tick();
        clear = 1'b0;
        chk("clr_flag", conflict, 0);
        chk("clr_clit", conflict_lit, 0);
        chk("clr_pcnt", push_cnt, 0);
        chk("clr_dcnt", dup_cnt, 0);
        #1;
        // +5 is new again; ptr=3 wraps to eng0.
        chk("aclr_ready", eng_ready, 4'b0001);
        chk("aclr_push", q_push, 1);
        chk("aclr_qdata", q_data, lv(5));
        tick();
        chk("aclr_pcnt", push_cnt, 1);

        // Invalid literal 0 from eng1 (ptr=1).
        eng_valid = '0;
        set_eng(1, 0, 1'b1);
        #1;
        chk("inv0_ready", eng_ready, 4'b0010);
        chk("inv0_push", q_push, 0);
        tick();
        chk("inv0_pcnt", push_cnt, 1);
        chk("inv0_dcnt", dup_cnt, 0);
        // Invalid -256 from eng2 (ptr=2).
        eng_valid = '0;
        set_eng(2, -256, 1'b1);
        #1;
        chk("inv256_ready", eng_ready, 4'b0100);
        chk("inv256_push", q_push, 0);
        tick();
        chk("inv256_pcnt", push_cnt, 1);
        chk("inv256_dcnt", dup_cnt, 0);
        chk("inv256_flag", conflict, 0);

        // Bring ptr from 3 to 0 with a push from eng3.
        eng_valid = '0;
        set_eng(3, 10, 1'b1);
        #1;
        chk("pre_rr_ready", eng_ready, 4'b1000);
        tick();
        chk("pre_rr_pcnt", push_cnt, 2);

        // Round-robin over +1..+4; each engine drops after its ack.
        set_eng(0, 1, 1'b1); set_eng(1, 2, 1'b1); set_eng(2, 3, 1'b1); set_eng(3, 4, 1'b1);
        #1;
        chk("rr0_ready", eng_ready, 4'b0001);
        chk("rr0_qdata", q_data, lv(1));
        tick();
        eng_valid[0] = 1'b0;
        #1;
        chk("rr1_ready", eng_ready, 4'b0010);
        chk("rr1_qdata", q_data, lv(2));
        tick();
        eng_valid[1] = 1'b0;
        #1;
        chk("rr2_ready", eng_ready, 4'b0100);
        chk("rr2_qdata", q_data, lv(3));
        tick();
        eng_valid[2] = 1'b0;
        #1;
        chk("rr3_ready", eng_ready, 4'b1000);
        chk("rr3_qdata", q_data, lv(4));
        chk("rr3_push", q_push, 1);
        tick();
        chk("rr_pcnt", push_cnt, 6);
        // Wrap: all re-request duplicates, eng0 must win.
        eng_valid = 4'b1111;
        #1;
        chk("wrap_ready", eng_ready, 4'b0001);
        chk("wrap_push", q_push, 0);
        tick();
        chk("wrap_dcnt", dup_cnt, 1);

        // Backpressure: eng3 holds -7 (ptr=1) for 3 full cycles.
        eng_valid = '0;
        set_eng(3, -7, 1'b1);
        q_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", eng_ready, 0);
            chk("bp_push", q_push, 0);
            tick();
        end
        q_full = 1'b0;
        #1;
        chk("bp_rel_ready", eng_ready, 4'b1000);
        chk("bp_rel_push", q_push, 1);
        chk("bp_rel_qdata", q_data, lv(-7));
        tick();
        chk("bp_pcnt", push_cnt, 7);

        // Conflict +7 from eng1 (ptr=0), then async reset mid-cycle.
        eng_valid = '0;
        set_eng(1, 7, 1'b1);
        #1;
        chk("cf2_ready", eng_ready, 4'b0010);
        tick();
        chk("cf2_lit", conflict_lit, lv(7));
        eng_valid = '0;
        set_eng(0, 5, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("ar_flag", conflict, 0);
        chk("ar_clit", conflict_lit, 0);
        chk("ar_pcnt", push_cnt, 0);
        chk("ar_dcnt", dup_cnt, 0);
        chk("ar_ready", eng_ready, 0);
        chk("ar_push", q_push, 0);
        tick();
        chk("ar_ready2", eng_ready, 0);
        chk("ar_push2", q_push, 0);
        chk("ar_pcnt2", push_cnt, 0);
        #1 rst = 1'b1;
        #1;
        // Table was zeroed: +5 is new again.
        chk("post_ar_ready", eng_ready, 4'b0001);
        chk("post_ar_push", q_push, 1);
        chk("post_ar_qdata", q_data, lv(5));
        tick();
        chk("post_ar_pcnt", push_cnt, 1);
        eng_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uc_arbiter.md
Name: uc_arbiter

Overview:
- Unit Clause Arbiter (uca) sits directly upstream of the Unit Clause Queue (ucq). It collects unit literals produced by NUM_ENG process engines and arbitrates among them round-robin.
- It filters duplicates against a per-variable assignment table and pushes only new literals into the ucq.
- It detects contradictory assignments and raises a sticky conflict.

Parameters:
- DATA_LEN, 512, literal encoding range; LIT_W = $clog2(DATA_LEN) = 9, signed.
- NUM_ENG, 4, number of engine request ports.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- clear  in  1  synchronous clear of table, conflict and counters (new problem or backtrack).
- eng_valid  in  NUM_ENG  per-engine unit-literal request.
- eng_lit  in  NUM_ENG x LIT_W  signed literal; magnitude = variable index, sign = polarity (negative = false).
- eng_ready  out  NUM_ENG  one-hot grant/ack; handshake completes when valid & ready.
- q_full  in  1  ucq full flag.
- q_push  out  1  push strobe to ucq.
- q_data  out  LIT_W  signed literal to ucq.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LIT_W  granted literal that caused the conflict.
- push_cnt  out  CNT_W  literals pushed since reset/clear, saturating.
- dup_cnt  out  CNT_W  duplicate literals dropped, saturating.

Behaviour:
- Reset (rst=0, async) sets these to 0: table, rr pointer, conflict, conflict_lit, push_cnt, dup_cnt. Outputs eng_ready, q_push and q_data are combinational and evaluate to 0 under reset.
- Variables: 1..2**(LIT_W-1)-1 (1..255). Table entry per variable = {assigned, value}.
- Arbitration:
  - Grant is evaluated only when q_full=0 and conflict=0; otherwise all eng_ready=0.
  - The winner is the first requesting engine at or after rr_ptr, with wrap.
  - At most one grant per cycle.
  - On grant, rr_ptr <= winner+1 mod NUM_ENG. With no grant, rr_ptr holds.
- Classification of the granted literal L, combinational, zero latency; table read is combinational:
  - Invalid (L==0 or L==-2**(LIT_W-1)): acked, dropped, no other effect.
  - New (variable unassigned): q_push=1, q_data=L in the same cycle. At the edge, table[var] <= {1, L>0}, and push_cnt increments.
  - Duplicate (assigned, same polarity): acked, no push, dup_cnt increments.
  - Conflict (assigned, opposite polarity): acked, no push. At the edge, conflict <= 1 and conflict_lit <= L.
- The table updates at the clock edge, so same-variable literals in consecutive cycles see the earlier assignment. No intra-cycle hazard exists because there is one grant per cycle.
- q_push is never asserted while q_full=1. No literal is lost: an ungranted engine must hold valid and lit stable.
- Conflict is sticky: it blocks all grants until clear or reset.
- clear has priority over a same-cycle grant:
  - The grant is still suppressed in that cycle (eng_ready=0, q_push=0).
  - Next state clears table, conflict, conflict_lit and counters.
  - rr_ptr is preserved.
- Counters saturate at 2**CNT_W-1.
- Reset mid-handshake: no grant completes and the table is zeroed. Engines re-present after reset.

Decomposition:
- Package uc_pkg holds:
  - LIT_W and NUM_VAR constants.
  - typedef lit_t (logic signed [LIT_W-1:0]).
  - typedef struct asg_t {assigned, value}.
  - enum lit_class_e {INVALID, NEW, DUP, CONFLICT}.
  - helper function lit_var(lit_t) returning the magnitude.
- Sub-module rr_arbiter (NUM_ENG requests, rr_ptr, one-hot grant), reused later for other multi-engine ports.

Test Plan:
- Basic push: eng0 presents +5, others idle -> eng_ready=0001, q_push=1, q_data=+5 in the same cycle; push_cnt=1 next cycle.
- Duplicate and conflict:
  - After +5, eng1 presents +5 -> acked, q_push=0, dup_cnt=1.
  - Then eng2 presents -5 -> acked, conflict=1 and conflict_lit=-5 next cycle.
  - All eng_ready=0 thereafter, even with requests pending.
- Round-robin: all four engines hold distinct new literals +1,+2,+3,+4 -> grants 0001,0010,0100,1000 in consecutive cycles; q_data sequence +1,+2,+3,+4; rr_ptr wraps to 0.
- Backpressure: q_full=1 for 3 cycles while eng3 holds -7 -> eng_ready=0, q_push=0 throughout; first cycle after q_full=0 -> push of -7.
- Clear and invalid:
  - clear pulse with eng0 requesting +5 in the same cycle -> no grant that cycle.
  - Next cycle +5 is classified new and pushed; conflict=0 and counters=0 after clear.
  - Literal 0 and -256 are acked with no push and no counter change.
- Async reset: rst low mid-stream between edges -> conflict, counters and conflict_lit read 0 immediately; eng_ready=0 and q_push=0 while rst is low.
